// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   Op codes     : 4-bit operation codes carried on the Op port
//   stateT       : FSM state encoding (IDLE, CALC, FIX)
//   cntWidth()   : width of the iteration counter, clog2(WIDTH/UNROLL)
package muldiv_pkg;

  typedef logic [3:0] opT;

  localparam opT MULT  = 4'd0;
  localparam opT MULTU = 4'd1;
  localparam opT DIV   = 4'd2;
  localparam opT DIVU  = 4'd3;
  localparam opT MTHI  = 4'd4;
  localparam opT MTLO  = 4'd5;
  localparam opT MADD  = 4'd6;
  localparam opT MADDU = 4'd7;
  localparam opT MSUB  = 4'd8;
  localparam opT MSUBU = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } stateT;

  // Counter holds WIDTH/UNROLL-1 down to 0; never narrower than one bit.
  function automatic int unsigned cntWidth(input int unsigned width, input int unsigned unroll);
    int unsigned iters;
    iters = width / unroll;
    return (iters > 1) ? $clog2(iters) : 1;
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
//   master (EX stage) drives : Start, Op, A, B, Flush, MfReq
//   slave  (muldiv unit)     : Busy, Done, Stall, Hi, Lo
interface ex_muldiv_unit_if
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  opT               Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Flush;
  logic             MfReq;
  logic             Busy;
  logic             Done;
  logic             Stall;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (output Start, Op, A, B, Flush, MfReq,
                  input  Busy, Done, Stall, Hi, Lo);
  modport slave  (input  Start, Op, A, B, Flush, MfReq,
                  output Busy, Done, Stall, Hi, Lo);
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the shared {hi,lo} work pair.
//   isDiv=0 : shift-add multiply step; hi is the partial product, lo the multiplier
//   isDiv=1 : restoring divide step; hi is the partial remainder, lo the dividend/quotient
// Ports: isDiv, hiIn/loIn (current pair), opnd (multiplicand or divisor), hiOut/loOut (next pair)
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             isDiv,
  input  logic [WIDTH-1:0] hiIn,
  input  logic [WIDTH-1:0] loIn,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hiOut,
  output logic [WIDTH-1:0] loOut
);

  logic [WIDTH:0]   addSum;
  logic [WIDTH:0]   remShift;
  logic [WIDTH-1:0] remDiff;

  // Compare rather than test the borrow so a zero divisor yields all-ones quotient.
  always_comb begin
    addSum   = {1'b0, hiIn} + (loIn[0] ? {1'b0, opnd} : (WIDTH + 1)'(0));
    remShift = {hiIn, loIn[WIDTH-1]};
    remDiff  = remShift[WIDTH-1:0] - opnd;
    hiOut    = addSum[WIDTH:1];
    loOut    = {addSum[0], loIn[WIDTH-1:1]};
    if (isDiv) begin
      if (remShift >= {1'b0, opnd}) begin
        hiOut = remDiff;
        loOut = {loIn[WIDTH-2:0], 1'b1};
      end else begin
        hiOut = remShift[WIDTH-1:0];
        loOut = {loIn[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO, beside the ALU in EX.
// Ports:
//   Clock : rising-edge clock
//   Reset : asynchronous active-low reset
//   bus   : ex_muldiv_unit_if.slave (Start/Op/A/B/Flush/MfReq in; Busy/Done/Stall/Hi/Lo out)
// Stall is combinational (Busy & (MfReq | Start)); all other outputs are registered.
// Optional: define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulate ops.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned UNROLL = 1
) (
  input logic              Clock,
  input logic              Reset,
  ex_muldiv_unit_if.slave  bus
);

  localparam int unsigned ITERS    = WIDTH / UNROLL;
  localparam int unsigned CW       = cntWidth(WIDTH, UNROLL);
  localparam logic [CW-1:0] CNT_INIT = CW'(ITERS - 1);

  stateT            state;
  logic [CW-1:0]    cnt;
  logic             busyQ, doneQ;
  logic [WIDTH-1:0] hiQ, loQ;
  logic [WIDTH-1:0] workHi, workLo, opnd;
  logic             isDiv, negRes, negRem;
  logic [WIDTH-1:0] stepHi, stepLo;

  // Operation decode and operand magnitudes for the issuing instruction.
  logic             opMul, opDiv, opSigned, signA, signB;
  logic [WIDTH-1:0] absA, absB;
  always_comb begin
    opMul    = 1'b0;
    opDiv    = 1'b0;
    opSigned = 1'b0;
    case (bus.Op)
      MULT:  begin opMul = 1'b1; opSigned = 1'b1; end
      MULTU: opMul = 1'b1;
      DIV:   begin opDiv = 1'b1; opSigned = 1'b1; end
      DIVU:  opDiv = 1'b1;
`ifdef MULDIV_MADD_EN
      MADD, MSUB:   begin opMul = 1'b1; opSigned = 1'b1; end
      MADDU, MSUBU: opMul = 1'b1;
`endif
      default: ;
    endcase
    signA = opSigned & bus.A[WIDTH-1];
    signB = opSigned & bus.B[WIDTH-1];
    absA  = signA ? -bus.A : bus.A;
    absB  = signB ? -bus.B : bus.B;
  end

`ifdef MULDIV_MADD_EN
  logic accEn, accSub, opAcc, opSub;
  assign opAcc = (bus.Op == MADD) | (bus.Op == MADDU) | (bus.Op == MSUB) | (bus.Op == MSUBU);
  assign opSub = (bus.Op == MSUB) | (bus.Op == MSUBU);
`endif

  // UNROLL iteration steps chained combinationally per CALC cycle.
  for (genvar i = 0; i < UNROLL; i++) begin : gStep
    logic [WIDTH-1:0] hiIn, loIn, hiNext, loNext;
    if (i == 0) begin : gFirst
      assign hiIn = workHi;
      assign loIn = workLo;
    end else begin : gChain
      assign hiIn = gStep[i-1].hiNext;
      assign loIn = gStep[i-1].loNext;
    end
    muldiv_step #(.WIDTH(WIDTH)) uStep (
      .isDiv (isDiv),
      .hiIn  (hiIn),
      .loIn  (loIn),
      .opnd  (opnd),
      .hiOut (hiNext),
      .loOut (loNext)
    );
  end
  assign stepHi = gStep[UNROLL-1].hiNext;
  assign stepLo = gStep[UNROLL-1].loNext;

  // Sign correction and final HI/LO values used in FIX.
  logic [2*WIDTH-1:0] prodMag, prodRes, hiLoNext;
  logic [WIDTH-1:0]   quot, rem;
  always_comb begin
    prodMag  = {workHi, workLo};
    prodRes  = negRes ? -prodMag : prodMag;
    hiLoNext = prodRes;
`ifdef MULDIV_MADD_EN
    if (accEn) hiLoNext = accSub ? ({hiQ, loQ} - prodRes) : ({hiQ, loQ} + prodRes);
`endif
    quot = negRes ? -workLo : workLo;
    rem  = negRem ? -workHi : workHi;
  end

  // Control FSM, work registers and architectural HI/LO.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
      hiQ    <= '0;
      loQ    <= '0;
      workHi <= '0;
      workLo <= '0;
      opnd   <= '0;
      isDiv  <= 1'b0;
      negRes <= 1'b0;
      negRem <= 1'b0;
`ifdef MULDIV_MADD_EN
      accEn  <= 1'b0;
      accSub <= 1'b0;
`endif
    end else begin
      doneQ <= 1'b0;
      if (bus.Flush) begin
        state <= IDLE;
        busyQ <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.Start) begin
              if (bus.Op == MTHI) begin
                hiQ <= bus.A;
              end else if (bus.Op == MTLO) begin
                loQ <= bus.A;
              end else if (opMul | opDiv) begin
                workHi <= '0;
                workLo <= absA;
                opnd   <= absB;
                isDiv  <= opDiv;
                // Divide by zero keeps the raw all-ones quotient.
                negRes <= (signA ^ signB) & ~(opDiv & (bus.B == '0));
                negRem <= signA;
                cnt    <= CNT_INIT;
                busyQ  <= 1'b1;
                state  <= CALC;
`ifdef MULDIV_MADD_EN
                accEn  <= opAcc;
                accSub <= opSub;
`endif
              end
            end
          end
          CALC: begin
            workHi <= stepHi;
            workLo <= stepLo;
            cnt    <= cnt - CW'(1);
            if (cnt == '0) state <= FIX;
          end
          FIX: begin
            if (isDiv) begin
              hiQ <= rem;
              loQ <= quot;
            end else begin
              {hiQ, loQ} <= hiLoNext;
            end
            doneQ <= 1'b1;
            busyQ <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.Busy  = busyQ;
  assign bus.Done  = doneQ;
  assign bus.Hi    = hiQ;
  assign bus.Lo    = loQ;
  assign bus.Stall = busyQ & (bus.MfReq | bus.Start);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;
  localparam int LAT = 33;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  ex_muldiv_unit_if #(.WIDTH(W)) bus ();
  ex_muldiv_unit #(.WIDTH(W), .UNROLL(1)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Behavioural model: architectural HI/LO, a countdown of busy cycles and the pending op.
  logic [W-1:0] mHi, mLo, pA, pB;
  logic         mDone;
  logic [3:0]   pOp;
  int           busyLeft;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit isMulDiv(input logic [3:0] op);
    bit r;
    r = op inside {MULT, MULTU, DIV, DIVU};
`ifdef MULDIV_MADD_EN
    r = r | (op inside {MADD, MADDU, MSUB, MSUBU});
`endif
    return r;
  endfunction

  function automatic void complete();
    longint sa, sb;
    logic [63:0] ua, ub, acc;
    sa  = longint'($signed(pA));
    sb  = longint'($signed(pB));
    ua  = {32'b0, pA};
    ub  = {32'b0, pB};
    acc = {mHi, mLo};
    case (pOp)
      MULT:  acc = sa * sb;
      MULTU: acc = ua * ub;
      DIV:   if (pB == 0) acc = {pA, 32'hFFFF_FFFF};
             else acc = {32'(sa % sb), 32'(sa / sb)};
      DIVU:  if (pB == 0) acc = {pA, 32'hFFFF_FFFF};
             else acc = {32'(ua % ub), 32'(ua / ub)};
`ifdef MULDIV_MADD_EN
      MADD:  acc = acc + 64'(sa * sb);
      MADDU: acc = acc + ua * ub;
      MSUB:  acc = acc - 64'(sa * sb);
      MSUBU: acc = acc - ua * ub;
`endif
      default: ;
    endcase
    mHi   = acc[63:32];
    mLo   = acc[31:0];
    mDone = 1'b1;
  endfunction

  // Advance the model across one rising edge using the inputs presented now.
  function automatic void modelEdge();
    mDone = 1'b0;
    if (bus.Flush) busyLeft = 0;
    else if (busyLeft > 0) begin
      busyLeft--;
      if (busyLeft == 0) complete();
    end else if (bus.Start) begin
      if (bus.Op == MTHI) mHi = bus.A;
      else if (bus.Op == MTLO) mLo = bus.A;
      else if (isMulDiv(bus.Op)) begin
        busyLeft = LAT;
        pOp = bus.Op;
        pA  = bus.A;
        pB  = bus.B;
      end
    end
  endfunction

  task automatic drive(input bit st, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit fl = 1'b0, input bit mf = 1'b0);
    bus.Start = st;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.Flush = fl;
    bus.MfReq = mf;
  endtask

  // One clock: check Stall before the edge, then all registered outputs after it.
  task automatic step();
    #1;
    chk("stall", 64'(bus.Stall), 64'((busyLeft > 0) && (bus.MfReq || bus.Start)));
    modelEdge();
    @(posedge Clock);
    #1;
    chk("busy", 64'(bus.Busy), 64'(busyLeft > 0));
    chk("done", 64'(bus.Done), 64'(mDone));
    chk("hi", 64'(bus.Hi), 64'(mHi));
    chk("lo", 64'(bus.Lo), 64'(mLo));
  endtask

  task automatic idle(input int n);
    drive(1'b0, 4'd0, '0, '0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic runOp(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int busyCycles);
    drive(1'b1, op, a, b);
    step();
    drive(1'b0, 4'd0, '0, '0);
    busyCycles = 0;
    for (int i = 0; i < 40 && !bus.Done; i++) begin
      if (bus.Busy) busyCycles++;
      step();
    end
    chk("done_seen", 64'(bus.Done), 64'd1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 9));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int bc;
    bit sawBusy;
    logic [3:0] rop;
    logic [W-1:0] ra, rb;

    drive(1'b0, 4'd0, '0, '0);
    mHi = '0; mLo = '0; mDone = 1'b0; busyLeft = 0; pOp = '0; pA = '0; pB = '0;
    #2 Reset = 1'b0;
    #4;
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    chk("rst_done", 64'(bus.Done), 64'd0);
    chk("rst_hi", 64'(bus.Hi), 64'd0);
    chk("rst_lo", 64'(bus.Lo), 64'd0);
    #2 Reset = 1'b1;
    @(posedge Clock);
    #1;

    // Reset mid-CALC discards the operation and the preloaded HI/LO.
    drive(1'b1, MTHI, 32'h1234, '0); step();
    drive(1'b1, MTLO, 32'h5678, '0); step();
    drive(1'b1, DIV, 32'd100, 32'd7); step();
    idle(4);
    Reset = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.Busy), 64'd0);
    chk("midrst_done", 64'(bus.Done), 64'd0);
    chk("midrst_hi", 64'(bus.Hi), 64'd0);
    chk("midrst_lo", 64'(bus.Lo), 64'd0);
    mHi = '0; mLo = '0; mDone = 1'b0; busyLeft = 0;
    #2 Reset = 1'b1;
    idle(40);

    // Multiply, signed and unsigned.
    runOp(MULT, 32'hFFFF_FFFD, 32'd5, bc);
    chk("mult_busy_cycles", 64'(bc), 64'd33);
    chk("mult_hi", 64'(bus.Hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(bus.Lo), 64'hFFFF_FFF1);
    runOp(MULTU, 32'hFFFF_FFFD, 32'd5, bc);
    chk("multu_hi", 64'(bus.Hi), 64'h4);
    chk("multu_lo", 64'(bus.Lo), 64'hFFFF_FFF1);

    // Divide cases including zero divisor and the overflow corner.
    runOp(DIV, 32'hFFFF_FFF9, 32'd2, bc);
    chk("div_lo", 64'(bus.Lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(bus.Hi), 64'hFFFF_FFFF);
    runOp(DIVU, 32'd7, 32'd0, bc);
    chk("divu0_lo", 64'(bus.Lo), 64'hFFFF_FFFF);
    chk("divu0_hi", 64'(bus.Hi), 64'd7);
    runOp(DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc);
    chk("divovf_lo", 64'(bus.Lo), 64'h8000_0000);
    chk("divovf_hi", 64'(bus.Hi), 64'd0);

    // Interlock: MfReq and a second Start while busy.
    drive(1'b1, MULT, 32'd6, 32'd7); step();
    for (int i = 1; i < 40 && !bus.Done; i++) begin
      if (i == 5) begin
        drive(1'b0, 4'd0, '0, '0, 1'b0, 1'b1);
        #1 chk("stall_mfreq", 64'(bus.Stall), 64'd1);
      end else if (i == 10) begin
        drive(1'b1, DIV, 32'd9, 32'd3);
        #1 chk("stall_start", 64'(bus.Stall), 64'd1);
      end else drive(1'b0, 4'd0, '0, '0);
      if (i == 20) begin
        chk("hold_hi", 64'(bus.Hi), 64'd0);
        chk("hold_lo", 64'(bus.Lo), 64'h8000_0000);
      end
      step();
    end
    chk("interlock_hi", 64'(bus.Hi), 64'd0);
    chk("interlock_lo", 64'(bus.Lo), 64'd42);

    // Flush mid-divide with a simultaneous MTLO, then a plain MTHI.
    drive(1'b1, DIVU, 32'd1000, 32'd3); step();
    idle(11);
    drive(1'b1, MTLO, 32'h55, '0, 1'b1); step();
    chk("flush_busy", 64'(bus.Busy), 64'd0);
    chk("flush_lo", 64'(bus.Lo), 64'd42);
    chk("flush_hi", 64'(bus.Hi), 64'd0);
    idle(35);
    drive(1'b1, MTHI, 32'hAA, '0); step();
    chk("mthi_hi", 64'(bus.Hi), 64'hAA);
    chk("mthi_busy", 64'(bus.Busy), 64'd0);

    // Accumulate op (legal only when the feature is built in).
    drive(1'b1, MTHI, 32'd0, '0); step();
    drive(1'b1, MTLO, 32'd10, '0); step();
    drive(1'b1, MADD, 32'd3, 32'd4); step();
    sawBusy = bus.Busy;
    drive(1'b0, 4'd0, '0, '0);
    for (int i = 0; i < 35; i++) begin
      sawBusy |= bus.Busy;
      step();
    end
    chk("madd_hi", 64'(bus.Hi), 64'd0);
`ifdef MULDIV_MADD_EN
    chk("madd_lo", 64'(bus.Lo), 64'd22);
    chk("madd_busy_seen", 64'(sawBusy), 64'd1);
`else
    chk("madd_lo", 64'(bus.Lo), 64'd10);
    chk("madd_busy_seen", 64'(sawBusy), 64'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rop = 4'($urandom_range(0, 11));
      ra  = pick();
      rb  = pick();
      drive($urandom_range(0, 3) == 0, rop, ra, rb,
            $urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0);
      step();
    end
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
